// File: rtl/ts_sync_aligner.sv
// MPEG2-TS packet aligner: locks onto the 0x47 sync byte with lock/loss flywheels,
// forwards packet-aligned bytes while locked and extracts PID/TEI per packet.
module ts_sync_aligner #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    PKT_LEN    = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE  = 8'h47,
  parameter int                    LOCK_COUNT = 3,
  parameter int                    LOSS_COUNT = 3
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  sop,
  output logic                  eop,
  output logic                  locked,
  output logic [12:0]           pid,
  output logic                  tei,
  output logic                  pid_valid,
  output logic                  sync_loss
);

  localparam int IDX_W   = $clog2(PKT_LEN);
  localparam int MAX_CNT = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] byte_idx_r;
  logic [CNT_W-1:0] good_cnt_r;
  logic [CNT_W-1:0] bad_cnt_r;
  logic [4:0]       pid_hi_r;
  logic             tei_cap_r;

  logic             idx_zero_s;
  logic             idx_last_s;
  logic [IDX_W-1:0] idx_next_s;
  logic             sync_hit_s;

  // Packet position decode and sync compare for the current input byte.
  always_comb begin
    idx_zero_s = (byte_idx_r == '0);
    idx_last_s = (byte_idx_r == IDX_W'(PKT_LEN - 1));
    sync_hit_s = (data_in == SYNC_BYTE);
    if (idx_last_s) begin
      idx_next_s = '0;
    end else begin
      idx_next_s = byte_idx_r + IDX_W'(1);
    end
  end

  // Alignment FSM with registered stream, marker and PID outputs.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state_r    <= HUNT;
      byte_idx_r <= '0;
      good_cnt_r <= '0;
      bad_cnt_r  <= '0;
      pid_hi_r   <= 5'd0;
      tei_cap_r  <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      sop        <= 1'b0;
      eop        <= 1'b0;
      locked     <= 1'b0;
      pid        <= 13'd0;
      tei        <= 1'b0;
      pid_valid  <= 1'b0;
      sync_loss  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      pid_valid <= 1'b0;
      sync_loss <= 1'b0;
      if (valid_in) begin
        case (state_r)
          HUNT: begin
            if (sync_hit_s) begin
              state_r    <= VERIFY;
              byte_idx_r <= IDX_W'(1);
              good_cnt_r <= CNT_W'(1);
            end else begin
              byte_idx_r <= '0;
            end
          end
          VERIFY: begin
            if (!idx_zero_s) begin
              byte_idx_r <= idx_next_s;
            end else if (sync_hit_s) begin
              byte_idx_r <= idx_next_s;
              if (good_cnt_r == CNT_W'(LOCK_COUNT - 1)) begin
                // The sync byte that completes acquisition is the first one forwarded.
                state_r    <= LOCKED;
                locked     <= 1'b1;
                good_cnt_r <= '0;
                bad_cnt_r  <= '0;
                data_out   <= data_in;
                valid_out  <= 1'b1;
                sop        <= 1'b1;
              end else begin
                good_cnt_r <= good_cnt_r + CNT_W'(1);
              end
            end else begin
              state_r    <= HUNT;
              byte_idx_r <= '0;
              good_cnt_r <= '0;
            end
          end
          LOCKED: begin
            if (idx_zero_s && !sync_hit_s && (bad_cnt_r == CNT_W'(LOSS_COUNT - 1))) begin
              state_r    <= HUNT;
              locked     <= 1'b0;
              sync_loss  <= 1'b1;
              byte_idx_r <= '0;
              good_cnt_r <= '0;
              bad_cnt_r  <= '0;
            end else begin
              data_out   <= data_in;
              valid_out  <= 1'b1;
              sop        <= idx_zero_s;
              eop        <= idx_last_s;
              byte_idx_r <= idx_next_s;
              if (idx_zero_s) begin
                // Flywheel: a missing sync is tolerated and the byte still marks sop.
                if (sync_hit_s) begin
                  bad_cnt_r <= '0;
                end else begin
                  bad_cnt_r <= bad_cnt_r + CNT_W'(1);
                end
              end else begin
                bad_cnt_r <= bad_cnt_r;
              end
              if (byte_idx_r == IDX_W'(1)) begin
                pid_hi_r  <= data_in[4:0];
                tei_cap_r <= data_in[7];
              end else if (byte_idx_r == IDX_W'(2)) begin
                pid       <= {pid_hi_r, data_in[7:0]};
                tei       <= tei_cap_r;
                pid_valid <= 1'b1;
              end else begin
                pid_hi_r  <= pid_hi_r;
              end
            end
          end
          default: begin
            state_r    <= HUNT;
            locked     <= 1'b0;
            byte_idx_r <= '0;
            good_cnt_r <= '0;
            bad_cnt_r  <= '0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_ts_sync_aligner.sv
// Directed-plus-random bench for ts_sync_aligner; a packet-level reference model
// predicts every cycle's outputs and immediate assertions compare them.
module tb_ts_sync_aligner;

  localparam int          PLEN = 188;
  localparam int          LOCK = 3;
  localparam int          LOSS = 3;
  localparam logic [7:0]  SYNC = 8'h47;

  logic        rclk;
  logic        rrst;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [7:0]  data_out;
  logic        valid_out;
  logic        sop;
  logic        eop;
  logic        locked;
  logic [12:0] pid;
  logic        tei;
  logic        pid_valid;
  logic        sync_loss;

  int n_checks = 0;
  int n_errors = 0;
  int vo_seen  = 0;

  logic [7:0] pkt [PLEN];

  // reference model state
  bit          m_lock;
  bit          m_cand;
  int          m_pos;
  int          m_good;
  int          m_bad;
  logic [7:0]  m_b1;
  logic [12:0] m_pid;
  bit          m_tei;
  bit          e_valid, e_sop, e_eop, e_pidv, e_loss;
  logic [7:0]  e_data;

  ts_sync_aligner dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .sop       (sop),
    .eop       (eop),
    .locked    (locked),
    .pid       (pid),
    .tei       (tei),
    .pid_valid (pid_valid),
    .sync_loss (sync_loss)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rnd_ns();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SYNC) b = 8'h48;
    return b;
  endfunction

  task automatic model_reset();
    m_lock = 1'b0; m_cand = 1'b0; m_pos = 0; m_good = 0; m_bad = 0;
    m_b1 = 8'h00; m_pid = 13'h0000; m_tei = 1'b0;
    e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_pidv = 1'b0; e_loss = 1'b0;
    e_data = 8'h00;
  endtask

  // Packet-level view: hunting, candidate alignment being confirmed, or locked.
  task automatic model_step(input logic [7:0] d, input bit v);
    e_valid = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_pidv = 1'b0; e_loss = 1'b0;
    if (!v) return;
    if (m_lock) begin
      if (m_pos == 0) begin
        if (d != SYNC) m_bad = m_bad + 1;
        else m_bad = 0;
      end
      if (m_bad == LOSS) begin
        m_lock = 1'b0; m_bad = 0; m_pos = 0; e_loss = 1'b1;
        return;
      end
      e_valid = 1'b1; e_data = d;
      e_sop = (m_pos == 0);
      e_eop = (m_pos == PLEN - 1);
      if (m_pos == 1) m_b1 = d;
      if (m_pos == 2) begin
        m_pid = {m_b1[4:0], d};
        m_tei = m_b1[7];
        e_pidv = 1'b1;
      end
      m_pos = (m_pos + 1) % PLEN;
    end else if (m_cand) begin
      if (m_pos == 0) begin
        if (d != SYNC) begin
          m_cand = 1'b0; m_good = 0;
          return;
        end
        m_good = m_good + 1;
        if (m_good == LOCK) begin
          m_cand = 1'b0; m_lock = 1'b1; m_good = 0; m_bad = 0;
          e_valid = 1'b1; e_sop = 1'b1; e_data = d;
        end
      end
      m_pos = (m_pos + 1) % PLEN;
    end else if (d == SYNC) begin
      m_cand = 1'b1; m_good = 1; m_pos = 1;
    end
  endtask

  task automatic check_model();
    chk("valid_out", valid_out, e_valid);
    chk("locked", locked, m_lock);
    chk("sync_loss", sync_loss, e_loss);
    chk("pid_valid", pid_valid, e_pidv);
    chk("pid", pid, m_pid);
    chk("tei", tei, m_tei);
    if (e_valid) begin
      chk("data_out", data_out, e_data);
      chk("sop", sop, e_sop);
      chk("eop", eop, e_eop);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_data"}, data_out, 8'h00);
    chk({tag, "_valid"}, valid_out, 1'b0);
    chk({tag, "_sop"}, sop, 1'b0);
    chk({tag, "_eop"}, eop, 1'b0);
    chk({tag, "_locked"}, locked, 1'b0);
    chk({tag, "_pid"}, pid, 13'h0000);
    chk({tag, "_tei"}, tei, 1'b0);
    chk({tag, "_pidv"}, pid_valid, 1'b0);
    chk({tag, "_loss"}, sync_loss, 1'b0);
  endtask

  task automatic cyc(input logic [7:0] d, input bit v);
    data_in  = d;
    valid_in = v;
    model_step(d, v);
    @(posedge rclk);
    #1;
    if (valid_out === 1'b1) vo_seen++;
    check_model();
  endtask

  task automatic do_reset(input int n);
    rrst     = 1'b1;
    valid_in = 1'b1;
    data_in  = SYNC;
    #1;
    model_reset();
    check_zero("rst_async");
    repeat (n) begin
      @(posedge rclk);
      #1;
      check_zero("rst_hold");
    end
    rrst = 1'b0;
  endtask

  task automatic fill_clean();
    for (int i = 0; i < PLEN; i++) pkt[i] = 8'(i);
    pkt[0] = SYNC;
    pkt[1] = 8'h1F;
    pkt[2] = 8'hFF;
  endtask

  task automatic fill_rand(input logic [7:0] b0);
    for (int i = 0; i < PLEN; i++) pkt[i] = rnd_ns();
    pkt[0] = b0;
  endtask

  task automatic send_buf(input int gaps);
    for (int i = 0; i < PLEN; i++) begin
      cyc(pkt[i], 1'b1);
      for (int g = 0; g < gaps; g++) cyc(8'($urandom), 1'b0);
    end
  endtask

  initial begin
    rrst     = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    model_reset();

    // reset while streaming sync bytes
    do_reset(3);

    // clean acquisition, no gaps
    fill_clean();
    vo_seen = 0;
    send_buf(0);
    send_buf(0);
    chk("no_out_first_2pkts", vo_seen, 0);
    send_buf(0);
    send_buf(0);
    chk("lock_clean", locked, 1'b1);
    chk("pid_clean", pid, 13'h1FFF);
    chk("tei_clean", tei, 1'b0);

    // throttled acquisition: valid 1,0,0,...
    do_reset(2);
    fill_clean();
    vo_seen = 0;
    send_buf(2);
    send_buf(2);
    chk("no_out_throttled", vo_seen, 0);
    send_buf(2);
    send_buf(2);
    chk("lock_throttled", locked, 1'b1);

    // single corruptions with a spurious payload sync, separated by good syncs
    fill_rand(8'h00);
    pkt[100] = SYNC;
    send_buf(0);
    chk("lock_after_1bad", locked, 1'b1);
    fill_rand(SYNC);  send_buf(0);
    fill_rand(8'h00); send_buf(0);
    fill_rand(8'h00); send_buf(0);
    fill_rand(SYNC);  send_buf(1);
    chk("lock_after_2bad_cleared", locked, 1'b1);

    // three consecutive missing syncs drop lock
    fill_rand(8'h00); send_buf(0);
    fill_rand(8'h00); send_buf(0);
    fill_rand(8'h00); send_buf(0);
    chk("unlocked_after_loss", locked, 1'b0);

    // false sync at a random offset, not confirmed one packet later
    vo_seen = 0;
    begin
      int off;
      off = $urandom_range(1, PLEN - 1);
      for (int i = 0; i < off; i++) cyc(rnd_ns(), 1'b1);
      cyc(SYNC, 1'b1);
      for (int i = 1; i < PLEN; i++) cyc(rnd_ns(), 1'b1);
      cyc(8'h00, 1'b1);
      for (int i = 0; i < 20; i++) cyc(rnd_ns(), 1'b1);
    end
    chk("no_out_false_sync", vo_seen, 0);
    chk("unlocked_false_sync", locked, 1'b0);

    // relock, then reset in the middle of a packet
    fill_clean();
    send_buf(0);
    send_buf(0);
    send_buf(0);
    chk("relock", locked, 1'b1);
    for (int i = 0; i < 90; i++) cyc(pkt[i], 1'b1);
    do_reset(2);
    vo_seen = 0;
    send_buf(0);
    send_buf(0);
    chk("no_out_after_midreset", vo_seen, 0);
    send_buf(0);
    chk("lock_after_midreset", locked, 1'b1);
    chk("pid_after_midreset", pid, 13'h1FFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
